pmod_debounce: RTL

PMOD_DEBOUNCE -- requirements
Module: pmod_debounce

---
 rtl/pmod_pkg.sv | 13 +
 rtl/pmod_debounce_bit.sv | 59 +++++
 rtl/pmod_debounce.sv | 73 +++++++
 3 files changed

// File: rtl/pmod_pkg.sv
// Shared defaults and sizing helper for the PMOD input debouncer.
package pmod_pkg;

    localparam int PMOD_WIDTH        = 8;
    localparam int PMOD_TICK_DIV     = 4800;
    localparam int PMOD_STABLE_TICKS = 50;

    // Bits needed to hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/pmod_debounce_bit.sv
// One PMOD pin: 2-flop synchronizer, tick-qualified disagreement counter,
// debounced level and registered rise/fall pulses.
module pmod_debounce_bit
    import pmod_pkg::*;
#(
    parameter int STABLE_TICKS = PMOD_STABLE_TICKS
) (
    input  logic CLK_48,
    input  logic RST_N,
    input  logic pin,
    input  logic tick,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int              CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          meta;
    logic          sync;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // NOTE: every flop, synchronizer included, clears asynchronously so a
    // reset mid-count discards any partially qualified level.
    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) begin
            meta     <= 1'b0;
            sync     <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep meta->sync a true two-stage
            // shift and let rise/fall see the previous stable value.
            meta     <= pin;
            sync     <= meta;
            stable_d <= stable;
            rise     <= stable & ~stable_d;
            fall     <= ~stable & stable_d;

            if (sync == stable) begin
                cnt <= '0;
            end else if (tick) begin
                // The final qualifying tick accepts the level instead of counting.
                if (cnt == CNT_LAST) begin
                    stable <= sync;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pmod_debounce.sv
// PMOD input debouncer: shared 100 us prescaler plus WIDTH per-pin debouncers.
// Define PMOD_DEBOUNCE_EVENT_EN to add sticky edge flags (evt/evt_clr) and irq.
module pmod_debounce
    import pmod_pkg::*;
#(
    parameter int WIDTH        = PMOD_WIDTH,
    parameter int TICK_DIV     = PMOD_TICK_DIV,
    parameter int STABLE_TICKS = PMOD_STABLE_TICKS
) (
    input  logic             CLK_48,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] pmod_in,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef PMOD_DEBOUNCE_EVENT_EN
    ,
    output logic [WIDTH-1:0] evt,
    input  logic [WIDTH-1:0] evt_clr,
    output logic             irq
`endif
);

    localparam int            PW       = cnt_width(TICK_DIV - 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = (pre == DIV_LAST);

    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        pmod_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .CLK_48 (CLK_48),
            .RST_N  (RST_N),
            .pin    (pmod_in[i]),
            .tick   (tick),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

`ifdef PMOD_DEBOUNCE_EVENT_EN
    // Set wins over a coincident clear; irq is registered from the same next value.
    logic [WIDTH-1:0] evt_next;

    assign evt_next = (evt & ~evt_clr) | rise | fall;

    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) begin
            evt <= '0;
            irq <= 1'b0;
        end else begin
            evt <= evt_next;
            irq <= |evt_next;
        end
    end
`endif

endmodule
